// File: rtl/ifu_fetch.sv
// Instruction fetch stage: PC register, held redirects and the IF/ID register.
// A redirect that arrives during a stall is held and applied once the stall drops.
module ifu_fetch #(
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter int          IM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic [31:0] im_instr,
   output logic [31:0] im_pc,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic        id_valid,
   output logic        id_exc_adel,
   output logic [31:0] fetch_count
);

   localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
   localparam logic [32:0] IM_HI = IM_LO + (33'(IM_WORDS) << 2);

   logic [31:0] pc_q, pc_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] pend_target_q, pend_target_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic        id_valid_q, id_valid_d;
   logic        id_exc_q, id_exc_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic        addr_err;

   // Misaligned or outside the instruction memory window (33-bit, no wrap)
   always_comb begin
      addr_err = (pc_q[1:0] != 2'b00)
               | ({1'b0, pc_q} < IM_LO)
               | ({1'b0, pc_q} >= IM_HI);
   end

   // Next PC and redirect held across a stall
   always_comb begin
      pc_d          = pc_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      if (!stall) begin
         pend_valid_d = 1'b0;
         if (redirect_valid) begin
            pc_d = redirect_target;
         end else if (pend_valid_q) begin
            pc_d = pend_target_q;
         end else begin
            pc_d = pc_q + 32'd4;
         end
      end else if (redirect_valid) begin
         pend_valid_d  = 1'b1;
         pend_target_d = redirect_target;
      end
   end

   // IF/ID load: flush bubbles even while stalled; redirect never squashes
   always_comb begin
      id_instr_d  = id_instr_q;
      id_pc_d     = id_pc_q;
      id_valid_d  = id_valid_q;
      id_exc_d    = id_exc_q;
      fetch_cnt_d = fetch_cnt_q;
      if (flush) begin
         id_instr_d = 32'd0;
         id_pc_d    = 32'd0;
         id_valid_d = 1'b0;
         id_exc_d   = 1'b0;
      end else if (!stall) begin
         id_instr_d  = addr_err ? 32'd0 : im_instr;
         id_pc_d     = pc_q;
         id_valid_d  = 1'b1;
         id_exc_d    = addr_err;
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q          <= IM_BASE;
         pend_valid_q  <= 1'b0;
         pend_target_q <= 32'd0;
         id_instr_q    <= 32'd0;
         id_pc_q       <= 32'd0;
         id_valid_q    <= 1'b0;
         id_exc_q      <= 1'b0;
         fetch_cnt_q   <= 32'd0;
      end else begin
         pc_q          <= pc_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
         id_instr_q    <= id_instr_d;
         id_pc_q       <= id_pc_d;
         id_valid_q    <= id_valid_d;
         id_exc_q      <= id_exc_d;
         fetch_cnt_q   <= fetch_cnt_d;
      end
   end

   assign im_pc       = pc_q;
   assign id_instr    = id_instr_q;
   assign id_pc       = id_pc_q;
   assign id_valid    = id_valid_q;
   assign id_exc_adel = id_exc_q;
   assign fetch_count = fetch_cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios then random traffic,
// checked against a cycle-level reference model and a memory array.
module tb_ifu_fetch;

   localparam logic [31:0] BASE  = 32'h0000_3000;
   localparam int          WORDS = 4096;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'd0;
   logic [31:0] im_instr;
   logic [31:0] im_pc;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        id_valid;
   logic        id_exc_adel;
   logic [31:0] fetch_count;

   int checks = 0;
   int failures = 0;

   logic [31:0] mem [0:WORDS-1];

   logic [31:0] m_pc, m_pt, m_instr, m_idpc, m_cnt;
   logic        m_pv, m_valid, m_exc;

   ifu_fetch #(.IM_BASE(BASE), .IM_WORDS(WORDS)) dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .flush(flush),
      .redirect_valid(redirect_valid),
      .redirect_target(redirect_target),
      .im_instr(im_instr),
      .im_pc(im_pc),
      .id_instr(id_instr),
      .id_pc(id_pc),
      .id_valid(id_valid),
      .id_exc_adel(id_exc_adel),
      .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   function automatic logic bad_addr(input logic [31:0] a);
      longint v;
      v = {32'd0, a};
      return (v % 4 != 0) || (v < longint'(BASE))
          || (v >= longint'(BASE) + 4 * WORDS);
   endfunction

   function automatic logic [31:0] mem_at(input logic [31:0] a);
      if (bad_addr(a)) return 32'hDEAD_BEEF;
      return mem[(a - BASE) >> 2];
   endfunction

   always_comb im_instr = mem_at(im_pc);

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".im_pc"}, im_pc, m_pc);
      chk({tag, ".id_instr"}, id_instr, m_instr);
      chk({tag, ".id_pc"}, id_pc, m_idpc);
      chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, m_valid});
      chk({tag, ".id_exc"}, {31'd0, id_exc_adel}, {31'd0, m_exc});
      chk({tag, ".count"}, fetch_count, m_cnt);
   endtask

   task automatic model_reset();
      m_pc = BASE; m_pv = 0; m_pt = 0;
      m_instr = 0; m_idpc = 0; m_valid = 0; m_exc = 0; m_cnt = 0;
   endtask

   // One clock: apply inputs, advance the model by the fetch rules, compare
   task automatic cyc(input logic s, input logic f, input logic rv,
                      input logic [31:0] rt, input string tag);
      logic [31:0] n_pc, n_pt;
      logic        n_pv;
      stall = s; flush = f; redirect_valid = rv; redirect_target = rt;
      n_pc = m_pc; n_pv = m_pv; n_pt = m_pt;
      if (!s) begin
         n_pv = 0;
         n_pc = rv ? rt : (m_pv ? m_pt : m_pc + 32'd4);
      end else if (rv) begin
         n_pv = 1; n_pt = rt;
      end
      if (f) begin
         m_instr = 0; m_idpc = 0; m_valid = 0; m_exc = 0;
      end else if (!s) begin
         m_exc = bad_addr(m_pc);
         m_instr = m_exc ? 32'd0 : mem_at(m_pc);
         m_idpc = m_pc; m_valid = 1; m_cnt = m_cnt + 1;
      end
      m_pc = n_pc; m_pv = n_pv; m_pt = n_pt;
      @(posedge clk);
      #1;
      chk_all(tag);
   endtask

   initial begin
      for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
      mem[0] = 32'h3401ffff;
      mem[1] = 32'h10210003;
      model_reset();

      // reset state while reset is held
      #12;
      chk_all("reset");
      reset = 1'b1;

      // sequential fetch
      cyc(0, 0, 0, 0, "seq0");
      chk("seq0.instr_lit", id_instr, 32'h3401ffff);
      cyc(0, 0, 0, 0, "seq1");
      chk("seq1.instr_lit", id_instr, 32'h10210003);
      chk("seq1.pc_lit", im_pc, 32'h3008);
      chk("seq1.cnt_lit", fetch_count, 32'd2);

      // stall with redirect, then stall held
      cyc(1, 0, 1, 32'h3020, "stl0");
      cyc(1, 0, 0, 0, "stl1");
      cyc(1, 0, 0, 0, "stl2");
      chk("stl2.pc_hold", im_pc, 32'h3008);
      cyc(0, 0, 0, 0, "stl3");
      chk("stl3.pc_lit", im_pc, 32'h3020);

      // address errors and the top of the window
      cyc(0, 0, 1, 32'h3002, "ae0");
      cyc(0, 0, 1, 32'h7000, "ae1");
      chk("ae1.exc_lit", {31'd0, id_exc_adel}, 32'd1);
      cyc(0, 0, 1, 32'h6FFC, "ae2");
      cyc(0, 0, 0, 0, "ae3");
      chk("ae3.exc_lit", {31'd0, id_exc_adel}, 32'd0);
      cyc(0, 0, 0, 0, "ae4");

      // flush beats stall
      cyc(1, 1, 0, 0, "fl0");
      cyc(0, 1, 1, 32'h3100, "fl1");

      // PC wrap
      cyc(0, 0, 1, 32'hFFFF_FFFC, "wr0");
      cyc(0, 0, 0, 0, "wr1");
      chk("wr1.pc_lit", im_pc, 32'h0);
      cyc(0, 0, 0, 0, "wr2");
      chk("wr2.exc_lit", {31'd0, id_exc_adel}, 32'd1);
      cyc(0, 0, 1, BASE, "wr3");

      // random traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] t;
         case ($urandom_range(0, 3))
            0: t = BASE + 4 * $urandom_range(0, WORDS - 1);
            1: t = BASE + 4 * $urandom_range(0, WORDS - 1) + 2;
            2: t = $urandom;
            default: case ($urandom_range(0, 2))
               0: t = BASE + 4 * WORDS - 4;
               1: t = BASE + 4 * WORDS;
               default: t = BASE - 4;
            endcase
         endcase
         cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 1,
             $urandom_range(0, 9) < 2, t, "rnd");
      end

      // async reset with a redirect pending
      cyc(1, 0, 1, 32'h3100, "ar0");
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      chk_all("ar_async");
      #2;
      reset = 1'b1;
      cyc(0, 0, 0, 0, "ar1");
      chk("ar1.idpc_lit", id_pc, BASE);
      cyc(0, 0, 0, 0, "ar2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter IM_BASE, default 32'h0000_3000, byte address of instruction-memory word 0.
REQ-002 SHALL have parameter IM_WORDS, default 4096, instruction-memory depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low (asserted at 0) reset.
REQ-005 SHALL have port stall  input  1  hazard stall from decode; freezes PC and IF/ID.
REQ-006 SHALL have port flush  input  1  clears IF/ID to bubble.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump taken; next PC comes from redirect_target.
REQ-008 SHALL have port redirect_target  input  32  redirect byte address.
REQ-009 SHALL have port im_instr  input  32  instruction word returned combinationally by instruction memory for im_pc.
REQ-010 SHALL have port im_pc  output  32  fetch byte address driven to instruction memory.
REQ-011 SHALL have port id_instr  output  32  IF/ID instruction.
REQ-012 SHALL have port id_pc  output  32  IF/ID PC.
REQ-013 SHALL have port id_valid  output  1  IF/ID holds a real fetch, not a bubble.
REQ-014 SHALL have port id_exc_adel  output  1  IF/ID fetch address error.
REQ-015 SHALL have port fetch_count  output  32  count of fetches latched into IF/ID with id_valid=1.

Function
REQ-016 SHALL drive im_pc from the PC register with no combinational dependence on any input.
REQ-017 SHALL compute addr_err = (pc[1:0]!=0) | pc<IM_BASE | pc>=IM_BASE+4*IM_WORDS, using 33-bit compare (no wrap).
REQ-018 SHALL, when stall=0, load PC by priority: redirect_valid -> redirect_target; else pending_valid -> pending_target; else pc+4 (mod 2^32).
REQ-019 SHALL clear pending_valid on every cycle with stall=0.
REQ-020 SHALL, when stall=1 and redirect_valid=1, hold PC, set pending_valid=1 and pending_target=redirect_target (latest redirect overwrites).
REQ-021 SHALL, when stall=1 and redirect_valid=0, hold PC and pending state unchanged.
REQ-022 SHALL NOT squash IF/ID on redirect; the fetch in flight is the delay slot and latches normally.
REQ-023 SHALL, when flush=1, load IF/ID with instr=0, pc=0, valid=0, exc_adel=0, regardless of stall (flush beats stall).
REQ-024 SHALL, when flush=0 and stall=0, load IF/ID with pc, valid=1, exc_adel=addr_err, instr = addr_err ? 0 : im_instr.
REQ-025 SHALL, when flush=0 and stall=1, hold all IF/ID fields.
REQ-026 SHALL increment fetch_count by 1 exactly on cycles satisfying REQ-024, wrapping at 2^32.
REQ-027 SHALL add zero cycles of latency: instruction at PC appears in IF/ID the edge after PC is presented with stall=0.
REQ-028 SHALL treat flush and redirect in the same cycle independently: IF/ID bubbles and PC redirects (or pends if stall=1).

Reset
REQ-029 SHALL, on reset=0, asynchronously set pc=IM_BASE, pending_valid=0, pending_target=0, id_instr=0, id_pc=0, id_valid=0, id_exc_adel=0, fetch_count=0.
REQ-030 SHALL, on reset mid-stall or with a pending redirect, discard the pending redirect; first fetch after release is at IM_BASE.
REQ-031 SHALL resume fetching on the first rising edge after reset deasserts.

Verification
REQ-032 SHALL cover sequential fetch: release reset, memory word0=32'h3401ffff, word1=32'h10210003 -> im_pc 0x3000,0x3004,0x3008; id_instr 3401ffff then 10210003; fetch_count 1,2.
REQ-033 SHALL cover stall+redirect: pc=0x3008, stall=1 with redirect_valid=1 target 0x3020 for 1 cycle, stall held 2 more cycles -> pc stays 0x3008, IF/ID frozen; after stall drops, pc=0x3020 next edge.
REQ-034 SHALL cover address error: redirect_target=0x3002 -> id_exc_adel=1, id_instr=0, id_valid=1; redirect to 0x7000 -> same; 0x6FFC -> no error.
REQ-035 SHALL cover flush during stall: stall=1, flush=1 -> id_valid=0, id_instr=0, fetch_count unchanged, pc held.
REQ-036 SHALL cover async reset mid-run: reset=0 between clock edges with pending_valid=1 -> all outputs zero and im_pc=0x3000 immediately, before the next edge.
REQ-037 SHALL cover PC wrap: redirect to 0xFFFFFFFC -> exc_adel=1; next pc=0x00000000, exc_adel=1.
